// File: rtl/bus_requester.sv
// Requester-side client for the req/res grant protocol: accepts burst jobs,
// holds req until every beat is granted or the grant wait times out.
module bus_requester #(
   parameter int LEN_W   = 4,
   parameter int GAP     = 1,
   parameter int TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             job_valid,
   input  logic [LEN_W-1:0] job_len,
   output logic             job_ready,
   output logic             req,
   input  logic             res,
   output logic             beat,
   output logic [LEN_W-1:0] beat_idx,
   output logic             done,
   output logic             timeout,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   // Handshake: a job transfers on a rising edge where job_valid && job_ready;
   // job_ready depends only on state, never on job_valid.
   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int GAP_W  = (GAP < 2) ? 1 : $clog2(GAP + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [LEN_W-1:0]  remaining;
   logic [LEN_W-1:0]  len_latched;
   logic [WAIT_W-1:0] wait_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              done_q;
   logic              timeout_q;
   logic              wait_last;
   logic              last_beat;
   logic              gap_done;
   logic              accept;
   logic              granted;

   assign granted   = (state == S_REQ || state == S_XFER) && res;
   assign wait_last = (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign last_beat = (remaining == LEN_W'(1));
   assign gap_done  = (gap_cnt >= GAP_W'(GAP));
   assign accept    = (state == S_IDLE) && job_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (job_valid && job_len != '0) state_n = S_REQ;
         end
         S_REQ: begin
            if (res) state_n = last_beat ? S_GAP : S_XFER;
            else if (wait_last) state_n = S_GAP;
         end
         S_XFER: begin
            if (!res) state_n = S_REQ;
            else if (last_beat) state_n = S_GAP;
         end
         S_GAP: begin
            // The arbiter holds res one cycle past our req drop; wait it out.
            if (gap_done && !res) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         remaining   <= '0;
         len_latched <= '0;
         wait_cnt    <= '0;
         gap_cnt     <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         if (accept) begin
            remaining   <= job_len;
            len_latched <= job_len;
         end else if (granted) begin
            remaining <= remaining - LEN_W'(1);
         end

         // Every entry into REQ comes from another state, so this clears it.
         if (state != S_REQ) wait_cnt <= '0;
         else if (!res) wait_cnt <= wait_cnt + WAIT_W'(1);

         if (state != S_GAP) gap_cnt <= '0;
         else if (!gap_done) gap_cnt <= gap_cnt + GAP_W'(1);

         done_q    <= (accept && job_len == '0) || (granted && last_beat);
         timeout_q <= (state == S_REQ) && !res && wait_last;
      end
   end

   always_comb begin
      req       = (state == S_REQ) || (state == S_XFER);
      job_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      beat      = granted;
      beat_idx  = len_latched - remaining;
      done      = done_q;
      timeout   = timeout_q;
      state_dbg = state;
   end

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: one instance on manual or arbitrated
// grant, a second instance sharing a small registered-grant arbiter.
module tb_bus_requester;

   localparam int LEN_W = 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic             reset;
   logic             a_job_valid, b_job_valid;
   logic [LEN_W-1:0] a_job_len, b_job_len;
   logic             a_job_ready, b_job_ready;
   logic             a_req, b_req, a_res, b_res;
   logic             a_beat, b_beat;
   logic [LEN_W-1:0] a_beat_idx, b_beat_idx;
   logic             a_done, b_done, a_timeout, b_timeout, a_busy, b_busy;
   logic [1:0]       a_state, b_state;
   logic             res_drv, arb_en, arb_a, arb_b;

   int checks = 0;
   int errors = 0;

   assign a_res = arb_en ? arb_a : res_drv;
   assign b_res = arb_en ? arb_b : 1'b0;

   // Registered-grant arbiter, A wins ties, grant held while req stays high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         arb_a <= 1'b0;
         arb_b <= 1'b0;
      end else begin
         arb_a <= a_req && (arb_a || !arb_b);
         arb_b <= b_req && (arb_b || (!arb_a && !a_req));
      end
   end

   bus_requester #(.LEN_W(LEN_W), .GAP(1), .TIMEOUT(15)) u_a (
      .clock(clock), .reset(reset), .job_valid(a_job_valid), .job_len(a_job_len),
      .job_ready(a_job_ready), .req(a_req), .res(a_res), .beat(a_beat),
      .beat_idx(a_beat_idx), .done(a_done), .timeout(a_timeout), .busy(a_busy),
      .state_dbg(a_state)
   );

   bus_requester #(.LEN_W(LEN_W), .GAP(1), .TIMEOUT(15)) u_b (
      .clock(clock), .reset(reset), .job_valid(b_job_valid), .job_len(b_job_len),
      .job_ready(b_job_ready), .req(b_req), .res(b_res), .beat(b_beat),
      .beat_idx(b_beat_idx), .done(b_done), .timeout(b_timeout), .busy(b_busy),
      .state_dbg(b_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [LEN_W-1:0] l, input logic r);
      a_job_valid = v;
      a_job_len   = l;
      res_drv     = r;
      #1;
   endtask

   initial begin
      int req_hi, to_n, to_at, dn, done_at, nbeat, an, bn, ad, bd, ad_at, bd_at;
      int both, a_drop, b_first;
      logic rdy17;
      logic [9:0] gl_pat;

      reset = 1'b0;
      a_job_valid = 1'b0; a_job_len = '0; b_job_valid = 1'b0; b_job_len = '0;
      res_drv = 1'b0; arb_en = 1'b0;

      // Reset values
      #12;
      chk("rst_req", 32'(a_req), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_done", 32'(a_done), 0);
      chk("rst_timeout", 32'(a_timeout), 0);
      #10 reset = 1'b1;
      tick();
      chk("rst_ready", 32'(a_job_ready), 1);

      // Nominal burst of 3, res follows req one cycle late
      drive(1, 3, 0);
      chk("nom_ready_c0", 32'(a_job_ready), 1);
      chk("nom_req_c0", 32'(a_req), 0);
      tick();
      drive(0, 0, 0);
      chk("nom_req_c1", 32'(a_req), 1);
      chk("nom_beat_c1", 32'(a_beat), 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1);
         chk("nom_beat", 32'(a_beat), 1);
         chk("nom_idx", 32'(a_beat_idx), 32'(i));
         chk("nom_done_early", 32'(a_done), 0);
         tick();
      end
      drive(0, 0, 1);
      chk("nom_req_c5", 32'(a_req), 0);
      chk("nom_done_c5", 32'(a_done), 1);
      chk("nom_beat_c5", 32'(a_beat), 0);
      tick();
      drive(0, 0, 0);
      chk("nom_done_c6", 32'(a_done), 0);
      chk("nom_ready_c6", 32'(a_job_ready), 0);
      tick();
      drive(0, 0, 0);
      chk("nom_ready_c7", 32'(a_job_ready), 1);
      chk("nom_busy_c7", 32'(a_busy), 0);

      // Zero length, then a len=2 job accepted the very next cycle
      drive(1, 0, 0);
      chk("zl_ready_c0", 32'(a_job_ready), 1);
      tick();
      drive(1, 2, 0);
      chk("zl_done_c1", 32'(a_done), 1);
      chk("zl_req_c1", 32'(a_req), 0);
      chk("zl_ready_c1", 32'(a_job_ready), 1);
      tick();
      drive(0, 0, 0);
      chk("zl_req_c2", 32'(a_req), 1);
      chk("zl_done_c2", 32'(a_done), 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 1);
         chk("zl_beat", 32'(a_beat), 1);
         chk("zl_idx", 32'(a_beat_idx), 32'(i));
         tick();
      end
      drive(0, 0, 1);
      chk("zl_done2", 32'(a_done), 1);
      tick();
      drive(0, 0, 0);
      tick();
      drive(0, 0, 0);
      chk("zl_ready_end", 32'(a_job_ready), 1);

      // Timeout: res tied low
      drive(1, 4, 0);
      tick();
      req_hi = 0; to_n = 0; to_at = 0; dn = 0; rdy17 = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         drive(0, 0, 0);
         if (a_req) req_hi++;
         if (a_timeout) begin to_n++; to_at = cyc; end
         if (a_done) dn++;
         if (cyc == 17) rdy17 = a_job_ready;
         tick();
      end
      chk("to_req_cycles", 32'(req_hi), 15);
      chk("to_pulses", 32'(to_n), 1);
      chk("to_cycle", 32'(to_at), 16);
      chk("to_no_done", 32'(dn), 0);
      chk("to_ready_c17", 32'(rdy17), 0);
      chk("to_ready_end", 32'(a_job_ready), 1);

      // Grant loss for two cycles after the first beat
      gl_pat = 10'b0011110010;
      drive(1, 4, 0);
      tick();
      nbeat = 0; dn = 0; done_at = 0;
      for (int c = 1; c <= 10; c++) begin
         drive(0, 0, gl_pat[c-1]);
         if (a_beat) begin
            chk("gl_idx", 32'(a_beat_idx), 32'(nbeat));
            nbeat++;
         end
         if (c == 3 || c == 4) begin
            chk("gl_req_held", 32'(a_req), 1);
            chk("gl_no_beat", 32'(a_beat), 0);
         end
         if (a_done) begin dn++; done_at = c; end
         tick();
      end
      chk("gl_beats", 32'(nbeat), 4);
      chk("gl_dones", 32'(dn), 1);
      chk("gl_done_cycle", 32'(done_at), 8);
      chk("gl_ready_end", 32'(a_job_ready), 1);

      // Reset asserted mid-burst
      drive(1, 5, 0);
      tick();
      drive(0, 0, 0);
      tick();
      drive(0, 0, 1);
      tick();
      drive(0, 0, 1);
      tick();
      drive(0, 0, 1);
      chk("mr_idx_before", 32'(a_beat_idx), 2);
      reset = 1'b0;
      #1;
      chk("mr_req", 32'(a_req), 0);
      chk("mr_busy", 32'(a_busy), 0);
      tick();
      chk("mr_done", 32'(a_done), 0);
      chk("mr_timeout", 32'(a_timeout), 0);
      drive(0, 0, 0);
      reset = 1'b1;
      tick();
      chk("mr_ready_after", 32'(a_job_ready), 1);
      chk("mr_busy_after", 32'(a_busy), 0);
      chk("mr_done_after", 32'(a_done), 0);

      // Two requesters on the arbiter
      arb_en = 1'b1;
      a_job_valid = 1'b1; a_job_len = 3; b_job_valid = 1'b1; b_job_len = 2;
      #1;
      chk("arb_a_ready", 32'(a_job_ready), 1);
      chk("arb_b_ready", 32'(b_job_ready), 1);
      tick();
      a_job_valid = 1'b0; b_job_valid = 1'b0;
      an = 0; bn = 0; ad = 0; bd = 0; ad_at = 0; bd_at = 0; both = 0; a_drop = 0; b_first = 0;
      for (int c = 1; c <= 14; c++) begin
         #1;
         if (a_res && b_res) both++;
         if (a_beat) an++;
         if (b_beat) bn++;
         if (a_done) begin ad++; ad_at = c; end
         if (b_done) begin bd++; bd_at = c; end
         if (!a_req && a_drop == 0) a_drop = c;
         if (b_res && b_first == 0) b_first = c;
         tick();
      end
      chk("arb_both_high", 32'(both), 0);
      chk("arb_a_beats", 32'(an), 3);
      chk("arb_b_beats", 32'(bn), 2);
      chk("arb_a_done", 32'(ad), 1);
      chk("arb_a_done_cycle", 32'(ad_at), 5);
      chk("arb_b_done", 32'(bd), 1);
      chk("arb_b_done_cycle", 32'(bd_at), 9);
      chk("arb_a_drop", 32'(a_drop), 5);
      chk("arb_b_first", 32'(b_first), 7);
      chk("arb_b_after_a", 32'(b_first > a_drop), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_requester.md
Name: bus_requester

Overview:
Requester-side client for the two-party req/res grant protocol. It accepts burst jobs from upstream with a valid/ready handshake, raises req, and waits for res. It counts granted beats, releases the bus, and enforces a post-release gap. One instance sits in front of each arbiter requester port: a_req/a_res or b_req/b_res.

Parameters:
LEN_W, 4, width of the job length field; maximum burst is 2^LEN_W-1 beats.
GAP, 1, minimum cycles (>=1) req stays low after a release before a new job is accepted.
TIMEOUT, 15, grant-wait limit in cycles (>=1) before the job is aborted.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
job_valid  input  1  upstream job offered.
job_len  input  LEN_W  number of beats in the offered job.
job_ready  output  1  block can accept a job this cycle.
req  output  1  bus request to the arbiter.
res  input  1  grant from the arbiter.
beat  output  1  a granted beat occurs this cycle.
beat_idx  output  LEN_W  0-based index of the current beat; valid when beat=1.
done  output  1  one-cycle pulse: job completed.
timeout  output  1  one-cycle pulse: job aborted, grant never arrived.
busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, REQ, XFER, GAP. All outputs except beat/beat_idx are decoded from registers; there is no res->req combinational path.
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters 0.
  - req=0, done=0, timeout=0, busy=0, job_ready=1 as soon as reset deasserts.
  - A job in flight is dropped with no done or timeout.
- Derived outputs:
  - req = (state==REQ || state==XFER).
  - beat = req & res (combinational).
  - beat_idx = len_latched - remaining.
  - job_ready = (state==IDLE).
- IDLE:
  - On job_valid=1, latch job_len into remaining.
  - If job_len==0: no bus activity; done=1 the next cycle; stay IDLE. Back-to-back acceptance is allowed.
  - Otherwise go to REQ; req is high from the next cycle.
- REQ:
  - wait_cnt clears on every entry to REQ.
  - If res=1: a beat occurs and remaining decrements.
    - remaining was 1: go to GAP; done=1 next cycle.
    - Otherwise go to XFER.
  - If res=0: wait_cnt increments. When wait_cnt==TIMEOUT-1, go to GAP; timeout=1 next cycle. req is therefore high for exactly TIMEOUT cycles.
- XFER:
  - On res=1: a beat occurs and remaining decrements. On the last beat go to GAP with done=1 next cycle.
  - On res=0 (grant lost): return to REQ holding req=1; no beat is counted and remaining is unchanged.
- GAP:
  - req=0; gap_cnt counts cycles.
  - Exit to IDLE only when gap_cnt>=GAP and res==0. The arbiter keeps res high one cycle past the req drop, so the block must see the grant withdrawn before it can re-request.
- done and timeout are mutually exclusive and last exactly 1 cycle.
- Nominal timing with a registered-grant arbiter:
  - job accepted in cycle 0 -> req=1 in cycle 1 -> res=1 in cycle 2.
  - Beats in cycles 2..len+1.
  - Cycle len+2: req=0 and done=1.
- job_len changes while busy are ignored.

Test Plan:
- Reset: hold reset=0 mid-burst (len=5, after beat 2) -> req=0 immediately; no done; after release job_ready=1, busy=0.
- Nominal: job_len=3 accepted cycle 0, res mirrors req delayed one cycle -> beat cycles 2,3,4 with beat_idx 0,1,2; done cycle 5; req=0 cycle 5; job_ready=1 cycle 7 with GAP=1, res low cycle 6.
- Zero length: job_len=0 -> req never rises; done=1 next cycle; job_ready stays 1; a second job with len=2 is accepted the following cycle.
- Timeout: job_len=4, res tied 0 -> req high exactly 15 cycles; timeout=1 the cycle after; done never asserts; back to IDLE after GAP.
- Grant loss: job_len=4; res drops for 2 cycles after beat 1 -> req stays 1; beat_idx resumes at 1; exactly 4 beats total; single done.
- Arbiter pairing: two instances on a_req/b_req of the grant arbiter, simultaneous jobs (3 and 2 beats) -> A served first; B granted only after A's req drops; no cycle with both res high; both done pulses seen.
